// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver/transmitter pair:
// FSM state encodings, frame geometry and a parity helper.
package serial_pkg;

    localparam int STATE_SIZE = 3;
    localparam int DATA_BITS  = 8;

    // Receiver FSM encodings (PARITY_BIT only used when parity is built in)
    localparam logic [STATE_SIZE-1:0] IDLE       = 3'd0;
    localparam logic [STATE_SIZE-1:0] START_BIT  = 3'd1;
    localparam logic [STATE_SIZE-1:0] DATA       = 3'd2;
    localparam logic [STATE_SIZE-1:0] STOP_BIT   = 3'd3;
    localparam logic [STATE_SIZE-1:0] WAIT_IDLE  = 3'd4;
    localparam logic [STATE_SIZE-1:0] PARITY_BIT = 3'd5;

    // Returns 1 when the number of ones in the byte plus the parity bit is odd,
    // i.e. when an even-parity frame is corrupted.
    function automatic logic even_parity_bad(input logic [DATA_BITS-1:0] d,
                                             input logic                 p);
        even_parity_bad = (^d) ^ p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin.
// Reset is asynchronous active-low; reset value is selectable so idle-high
// lines do not produce a false edge when reset is released.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/serial_rx.sv
// UART-style serial receiver, 8 data bits LSB first, 1 stop bit, idle-high.
// One bit every CLK_PER_BIT clocks; the start bit is checked at its middle,
// data/stop bits are sampled one full bit period after that.
// Optional build macro SERIAL_RX_PARITY_EN adds an even-parity bit between
// bit 7 and the stop bit and a parity_err strobe output.
module serial_rx
    import serial_pkg::*;
#(
    parameter  int CLK_PER_BIT = 50,
    localparam int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 new_data,
    output logic                 frame_err,
    output logic                 busy
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam logic [CTR_SIZE-1:0] CTR_HALF = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_SIZE-1:0] CTR_LAST = CTR_SIZE'(CLK_PER_BIT - 1);
    localparam logic [CTR_SIZE-1:0] CTR_ONE  = CTR_SIZE'(1);

    logic                  rx_sync;

    logic [STATE_SIZE-1:0] state_r,      state_n;
    logic [CTR_SIZE-1:0]   ctr_r,        ctr_n;
    logic [2:0]            bit_ctr_r,    bit_ctr_n;
    logic [DATA_BITS-1:0]  shift_r,      shift_n;
    logic [DATA_BITS-1:0]  data_r,       data_n;
    logic                  new_data_r,   new_data_n;
    logic                  frame_err_r,  frame_err_n;
    logic                  busy_r,       busy_n;
`ifdef SERIAL_RX_PARITY_EN
    logic                  parity_r,     parity_n;
    logic                  parity_err_r, parity_err_n;
`endif

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_sync)
    );

    // Next-state logic: bit timing, sampling and result strobes
    always_comb begin
        state_n      = state_r;
        ctr_n        = ctr_r;
        bit_ctr_n    = bit_ctr_r;
        shift_n      = shift_r;
        data_n       = data_r;
        new_data_n   = 1'b0;
        frame_err_n  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_n     = parity_r;
        parity_err_n = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                ctr_n     = '0;
                bit_ctr_n = 3'd0;
                if (!rx_sync) begin
                    state_n = START_BIT;
                end else begin
                    state_n = IDLE;
                end
            end
            START_BIT: begin
                if (ctr_r == CTR_HALF) begin
                    ctr_n = '0;
                    // Line back high at mid start bit: treat as a glitch
                    if (!rx_sync) begin
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    ctr_n = ctr_r + CTR_ONE;
                end
            end
            DATA: begin
                if (ctr_r == CTR_LAST) begin
                    ctr_n              = '0;
                    shift_n[bit_ctr_r] = rx_sync;
                    bit_ctr_n          = bit_ctr_r + 3'd1;
                    if (bit_ctr_r == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = PARITY_BIT;
`else
                        state_n = STOP_BIT;
`endif
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    ctr_n = ctr_r + CTR_ONE;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY_BIT: begin
                if (ctr_r == CTR_LAST) begin
                    ctr_n    = '0;
                    parity_n = rx_sync;
                    state_n  = STOP_BIT;
                end else begin
                    ctr_n = ctr_r + CTR_ONE;
                end
            end
`endif
            STOP_BIT: begin
                if (ctr_r == CTR_LAST) begin
                    ctr_n = '0;
                    if (rx_sync) begin
                        state_n = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (even_parity_bad(shift_r, parity_r)) begin
                            parity_err_n = 1'b1;
                        end else begin
                            data_n     = shift_r;
                            new_data_n = 1'b1;
                        end
`else
                        data_n     = shift_r;
                        new_data_n = 1'b1;
`endif
                    end else begin
                        // Bad stop bit: keep the old byte, wait out a break
                        frame_err_n = 1'b1;
                        state_n     = WAIT_IDLE;
                    end
                end else begin
                    ctr_n = ctr_r + CTR_ONE;
                end
            end
            WAIT_IDLE: begin
                ctr_n = '0;
                if (rx_sync) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_IDLE;
                end
            end
            default: begin
                state_n   = IDLE;
                ctr_n     = '0;
                bit_ctr_n = 3'd0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            ctr_r        <= '0;
            bit_ctr_r    <= 3'd0;
            shift_r      <= 8'h00;
            data_r       <= 8'h00;
            new_data_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_r     <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r      <= state_n;
            ctr_r        <= ctr_n;
            bit_ctr_r    <= bit_ctr_n;
            shift_r      <= shift_n;
            data_r       <= data_n;
            new_data_r   <= new_data_n;
            frame_err_r  <= frame_err_n;
            busy_r       <= busy_n;
`ifdef SERIAL_RX_PARITY_EN
            parity_r     <= parity_n;
            parity_err_r <= parity_err_n;
`endif
        end
    end

    assign data      = data_r;
    assign new_data  = new_data_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx with CLK_PER_BIT=50.
// Frames are driven bit-exact on the falling clock edge; every expected
// strobe (byte + arrival cycle) is queued when its frame starts and checked
// by a monitor on the falling edge when the DUT raises the strobe.
module tb_serial_rx;

    localparam int CPB = 50;
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    localparam int K_BYTE = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       new_data;
    logic       frame_err;
    logic       busy;
`ifdef SERIAL_RX_PARITY_EN
    logic       parity_err;
`endif

    serial_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .new_data  (new_data),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef SERIAL_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t q_byte[$];
    int   q_fe[$];
    int   q_pe[$];

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        int         stop_len;
        int         gap;
        int         kind;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one frame starting at the current falling edge; queue its outcome.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int stop_len, input int kind);
        int   st;
        exp_t e;
        rx = 1'b0;
        st = cyc;
        if (kind == K_BYTE) begin
            e.d   = d;
            e.cyc = st + LAT;
            q_byte.push_back(e);
        end else if (kind == K_FERR) begin
            q_fe.push_back(st + LAT);
        end else begin
            q_pe.push_back(st + LAT);
        end
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef SERIAL_RX_PARITY_EN
        rx = par;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop;
        repeat (stop_len) @(negedge clk);
    endtask

    // Strobe monitor: every strobe must match the head of its queue
    always @(negedge clk) begin
        if (rst) begin
            if (new_data) begin
                chk("frame_err_with_new_data", frame_err, 1'b0);
                if (q_byte.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_new_data: got data %0h at cycle %0d, expected no strobe", data, cyc);
                end else begin
                    exp_t e;
                    e = q_byte.pop_front();
                    chk("data", data, e.d);
                    chk("new_data_cycle", cyc, e.cyc);
                end
            end
            if (frame_err) begin
                if (q_fe.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_frame_err: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    chk("frame_err_cycle", cyc, q_fe.pop_front());
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            if (parity_err) begin
                chk("new_data_with_parity_err", new_data, 1'b0);
                if (q_pe.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_parity_err: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    chk("parity_err_cycle", cyc, q_pe.pop_front());
                end
            end
`endif
        end
    end

    initial begin
        // Vector table: byte, parity, stop, stop length, idle gap after, outcome
        vecs.push_back('{8'hA5, 1'b0, 1'b1, CPB, 20, K_BYTE});
        vecs.push_back('{8'h00, 1'b0, 1'b1, CPB, 0,  K_BYTE});
        vecs.push_back('{8'hFF, 1'b0, 1'b1, CPB, 30, K_BYTE});
`ifdef SERIAL_RX_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b1, CPB, 20, K_BYTE});
        vecs.push_back('{8'h07, 1'b0, 1'b1, CPB, 20, K_PERR});
        vecs.push_back('{8'hC3, 1'b0, 1'b1, CPB, 20, K_BYTE});
`endif

        // Reset state
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", data, 8'h00);
        chk("reset_new_data", new_data, 1'b0);
        chk("reset_frame_err", frame_err, 1'b0);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, vecs[i].stop_len, vecs[i].kind);
            if (vecs[i].kind == K_BYTE) begin
                last_good = vecs[i].d;
            end
            repeat (vecs[i].gap) @(negedge clk);
        end
        chk("data_hold_after_table", data, last_good);

        // Short low glitch on an idle line
        begin
            rx = 1'b0;
            repeat (5) @(negedge clk);
            chk("glitch_busy_high", busy, 1'b1);
            repeat (5) @(negedge clk);
            rx = 1'b1;
            repeat (30) @(negedge clk);
            chk("glitch_busy_low", busy, 1'b0);
            chk("glitch_data_hold", data, last_good);
        end

        // Bad stop bit followed by a long break, then a normal frame
        begin
            send_frame(8'h3C, 1'b0, 1'b0, 190, K_FERR);
            chk("break_busy_high", busy, 1'b1);
            chk("break_data_hold", data, last_good);
            chk("break_frame_err_seen", q_fe.size(), 0);
            repeat (10) @(negedge clk);
            rx = 1'b1;
            repeat (5) @(negedge clk);
            chk("break_busy_low", busy, 1'b0);
            repeat (20) @(negedge clk);
            send_frame(8'h5A, 1'b0, 1'b1, CPB, K_BYTE);
            repeat (20) @(negedge clk);
            chk("after_break_data", data, 8'h5A);
        end

        // Reset in the middle of data bit 4
        begin
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rx = 1'b1;
                repeat (CPB) @(negedge clk);
            end
            rx = 1'b1;
            repeat (20) @(negedge clk);
            chk("midframe_busy_before_reset", busy, 1'b1);
            rst = 1'b0;
            #1;
            chk("midframe_reset_data", data, 8'h00);
            chk("midframe_reset_busy", busy, 1'b0);
            chk("midframe_reset_new_data", new_data, 1'b0);
            chk("midframe_reset_frame_err", frame_err, 1'b0);
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (300) @(negedge clk);
            chk("midframe_no_strobe_data", data, 8'h00);
            send_frame(8'h81, 1'b0, 1'b1, CPB, K_BYTE);
            repeat (20) @(negedge clk);
            chk("after_reset_data", data, 8'h81);
        end

        // Every queued strobe must have been seen
        chk("pending_bytes", q_byte.size(), 0);
        chk("pending_frame_errs", q_fe.size(), 0);
        chk("pending_parity_errs", q_pe.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
